// File: rtl/frame_parser_param.sv
// -----------------------------------------------------------------------------
// frame_parser_param
//
// Byte-stream frame parser. Hunts for PREAMBLE followed by SFD on consecutive
// valid beats, then walks TYPE -> [LEN] -> DATA -> FCS. Every frame byte from
// TYPE through the last FCS byte is forwarded with sop/eop marks. Frames with
// an illegal length end on their last LEN byte with eop+err. Frames that stall
// mid-way for TIMEOUT idle cycles are dropped with a one-cycle abort pulse.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   din        in   8   input byte
//   din_vld    in   1   din qualifier; parsing advances only when high
//   dout       out  8   forwarded byte (last valid input byte)
//   dout_vld   out  1   dout is a frame byte (TYPE..last FCS)
//   dout_sop   out  1   dout is the TYPE byte
//   dout_eop   out  1   dout is the last byte of the frame
//   dout_err   out  1   qualifies dout_eop: length error
//   abort      out  1   one-cycle pulse, frame dropped by idle timeout
//   frame_len  out  16  payload length of the current frame
//   good_cnt   out  16  good frames, saturating
//   bad_cnt    out  16  length-error and timed-out frames, saturating
// -----------------------------------------------------------------------------
module frame_parser_param #(
    parameter logic [7:0] PREAMBLE  = 8'h55,
    parameter logic [7:0] SFD       = 8'hD5,
    parameter int         LEN_BYTES = 2,
    parameter int         DEF_LEN   = 64,
    parameter int         FCS_BYTES = 4,
    parameter int         MAX_LEN   = 1500,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_err,
    output logic        abort,
    output logic [15:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam int LW = 8 * LEN_BYTES;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_HEAD,
        S_TYPE,
        S_LEN,
        S_DATA,
        S_FCS
    } state_t;

    state_t          state_reg;
    logic [7:0]      prev_reg;     // previous valid byte, tracked in every state
    logic [15:0]     cnt_reg;      // byte index within the current state
    logic [LW-1:0]   len_reg;      // payload length, shifted in MSB first
    logic [IW-1:0]   idle_reg;     // consecutive idle cycles inside a frame

    logic [LW-1:0]   len_shift;
    logic            len_bad;
    logic            len_last;
    logic            data_last;
    logic            fcs_last;
    logic            idle_expire;

    // Length value as it will stand once the current LEN byte is shifted in.
    assign len_shift   = (len_reg << 8) | LW'(din);
    assign len_bad     = (len_shift == '0) || (32'(len_shift) > 32'(MAX_LEN));
    assign len_last    = (cnt_reg == 16'(LEN_BYTES - 1));
    assign data_last   = (32'(cnt_reg) == (32'(len_reg) - 32'd1));
    assign fcs_last    = (cnt_reg == 16'(FCS_BYTES - 1));
    // Current idle cycle is the TIMEOUT-th in a row.
    assign idle_expire = (32'(idle_reg) == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_HEAD;
            prev_reg  <= 8'h00;
            cnt_reg   <= 16'd0;
            len_reg   <= '0;
            idle_reg  <= '0;
            dout      <= 8'h00;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout_err  <= 1'b0;
            abort     <= 1'b0;
            frame_len <= 16'd0;
            good_cnt  <= 16'd0;
            bad_cnt   <= 16'd0;
        end else begin
            // Marks are per-beat; they drop whenever no beat was accepted.
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            abort    <= 1'b0;

            if (din_vld) begin
                idle_reg <= '0;
                prev_reg <= din;
                dout     <= din;
                dout_vld <= (state_reg != S_HEAD);

                case (state_reg)
                    S_HEAD: begin
                        if (prev_reg == PREAMBLE && din == SFD) begin
                            state_reg <= S_TYPE;
                            cnt_reg   <= 16'd0;
                        end
                    end

                    S_TYPE: begin
                        dout_sop <= 1'b1;
                        cnt_reg  <= 16'd0;
                        if (din == 8'h00) begin
                            state_reg <= S_DATA;
                            len_reg   <= LW'(DEF_LEN);
                            frame_len <= 16'(DEF_LEN);
                        end else begin
                            state_reg <= S_LEN;
                            len_reg   <= '0;
                            frame_len <= 16'd0;
                        end
                    end

                    S_LEN: begin
                        len_reg <= len_shift;
                        if (len_last) begin
                            cnt_reg   <= 16'd0;
                            frame_len <= 16'(len_shift);
                            if (len_bad) begin
                                dout_eop  <= 1'b1;
                                dout_err  <= 1'b1;
                                bad_cnt   <= (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'd1;
                                state_reg <= S_HEAD;
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end

                    S_DATA: begin
                        if (data_last) begin
                            cnt_reg   <= 16'd0;
                            state_reg <= S_FCS;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end

                    S_FCS: begin
                        if (fcs_last) begin
                            cnt_reg   <= 16'd0;
                            dout_eop  <= 1'b1;
                            good_cnt  <= (good_cnt == 16'hFFFF) ? good_cnt : good_cnt + 16'd1;
                            state_reg <= S_HEAD;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end

                    default: begin
                        state_reg <= S_HEAD;
                        cnt_reg   <= 16'd0;
                    end
                endcase
            end else if (state_reg != S_HEAD) begin
                // Stalled mid-frame: drop the frame after TIMEOUT idle cycles.
                if (idle_expire) begin
                    abort     <= 1'b1;
                    bad_cnt   <= (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'd1;
                    state_reg <= S_HEAD;
                    cnt_reg   <= 16'd0;
                    idle_reg  <= '0;
                end else begin
                    idle_reg <= idle_reg + 1'b1;
                end
            end else begin
                idle_reg <= '0;
            end
        end
    end

endmodule
